alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised multi-cycle ALU for the RISCV-Lite execute stage. It replaces the fixed 32-bit single-cycle ALU, whose shifts had constant amounts.
- Adds variable shift amounts (SLL/SRL/SRA by op2), set-less-than, and the full branch-compare set.
- Results are registered and delivered over valid/ready handshakes. Shifts run iteratively at SHIFT_STEP bits per cycle.

Parameters:
- WIDTH, 32: operand and result width (>=8, power of 2).
- SHIFT_STEP, 1: maximum bit positions shifted per cycle in SHIFT state (power of 2, <=WIDTH).

Ports:
- CLK  in  1  clock, rising edge.
- RST_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- op1  in  WIDTH  first operand.
- op2  in  WIDTH  second operand; for shifts, op2[$clog2(WIDTH)-1:0] is the amount, upper bits ignored.
- ALUControl  in  alu_op_e  operation select.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- ALUResult  out  WIDTH  registered result.
- BIT_Branch  out  1  registered branch-taken flag.
- busy  out  1  high in SHIFT state.

Behaviour:
- Reset (async, RST_n=0): state=IDLE; ALUResult=0, BIT_Branch=0, out_valid=0, busy=0; internal accumulator and counter cleared. in_ready=0 while RST_n=0 and is 1 after release.
- States:
  - IDLE: in_ready=1.
  - SHIFT: busy=1, in_ready=0.
  - DONE: out_valid=1; in_ready=out_ready.
- Accept condition: in_valid & in_ready.
- Accepting a non-shift op, or a shift with amount 0: result and flag are registered; go to DONE. out_valid is high the cycle after acceptance (latency 1).
- Accepting a shift with amount s>0: acc=op1, rem=s, shift type latched; go to SHIFT.
  - Each SHIFT cycle: acc shifted by k=min(SHIFT_STEP, rem); rem-=k.
  - When rem becomes 0, the final acc goes to ALUResult and the state goes to DONE.
  - out_valid rises 1+ceil(s/SHIFT_STEP) cycles after acceptance.
  - SRA fills with acc[WIDTH-1]; SLL/SRL fill with 0.
- DONE, out_ready=1:
  - Result consumed.
  - If a new request is accepted the same cycle, the state follows the acceptance rules above (back-to-back, no bubble for 1-cycle ops).
  - Otherwise go to IDLE and clear out_valid.
- DONE, out_ready=0: ALUResult, BIT_Branch and out_valid hold stable; no new request is accepted.
- Operation results (all arithmetic modulo 2^WIDTH):
  - ADD: op1+op2.
  - SUB: op1-op2.
  - XOR, OR, AND: bitwise.
  - SLT: signed op1<op2 zero-extended to WIDTH.
  - SLTU: unsigned op1<op2 zero-extended to WIDTH.
  - SLL, SRL, SRA: as above.
- Branch ops: ALUResult=op1-op2. BIT_Branch by op:
  - BEQ: op1==op2.
  - BNE: op1!=op2.
  - BLT: signed op1<op2.
  - BGE: signed op1>=op2.
  - BLTU: unsigned op1<op2.
  - BGEU: unsigned op1>=op2.
- BIT_Branch=0 for all non-branch ops.
- Unknown ALUControl encoding: ALUResult=op1-op2, BIT_Branch=0, latency 1.
- Inputs are sampled only on acceptance; later changes to op1/op2/ALUControl during SHIFT or DONE have no effect.
- Reset asserted mid-SHIFT or mid-DONE: immediate return to the reset values; the pending result is discarded.

Decomposition:
- Shared package my_pkg:
  - alu_op_e enum: ADD, SUB, XOR, OR, AND, SLL, SRL, SRA, SLT, SLTU, BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - alu_state_e: IDLE, SHIFT, DONE.
  - Existing enum values are kept for backward compatibility.
- Sub-module alu_shift_step: combinational, shifts a WIDTH value by a variable amount 0..SHIFT_STEP with direction/arith select. Instantiated once in the SHIFT datapath.

Test Plan:
- Reset: hold RST_n=0 mid-SHIFT (SLL op1=1, op2=31) -> outputs immediately 0; after release, in_ready=1, out_valid=0.
- ADD 0xFFFFFFFF+1, out_ready=1 -> out_valid next cycle, ALUResult=0x00000000, BIT_Branch=0. Back-to-back XOR 0xF0F0F0F0^0xFFFF0000 on the following cycle -> 0x0F0FF0F0, one cycle later.
- SRA op1=0x80000000, op2=31, SHIFT_STEP=1 -> busy 31 cycles, out_valid at cycle 32 after acceptance, ALUResult=0xFFFFFFFF. With SHIFT_STEP=4 -> out_valid at cycle 9, same value. op2=0x20 (amount 0) -> latency 1, result=op1.
- Branch compares, op1=0xFFFFFFFF, op2=1:
  - BLT -> BIT_Branch=1; BLTU -> 0; BGEU -> 1.
  - BEQ 5,5 -> 1; BNE 5,5 -> 0.
  - ALUResult=op1-op2 in each case.
- Backpressure: result 0x3 (ADD 1+2) with out_ready=0 for 5 cycles while op1/op2 toggle and in_valid=1 -> ALUResult stable at 0x3, in_ready=0. Raise out_ready -> result consumed and the pending request accepted in the same cycle.
- SLT -5 vs 3 -> 1; SLTU 0xFFFFFFFB vs 3 -> 0; unknown encoding with 7,2 -> ALUResult=5, BIT_Branch=0.

Source files
------------

// File: rtl/my_pkg.sv
// my_pkg: operation and state types shared by the multi-cycle ALU.
package my_pkg;

    // 5-bit encoding leaves headroom for future ops; unused codes decode as SUB without a branch flag.
    typedef enum logic [4:0] {
        ADD, SUB, XOR, OR, AND, SLL, SRL, SRA, SLT, SLTU, BEQ, BNE, BLT, BGE, BLTU, BGEU
    } alu_op_e;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} alu_state_e;

    function automatic logic is_shift(input alu_op_e op);
        return op inside {SLL, SRL, SRA};
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// alu_shift_step: one iteration of the shifter, moving a word by 0..SHIFT_STEP bits.
module alu_shift_step #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 1,
    localparam int AW        = $clog2(SHIFT_STEP + 1)
) (
    input  logic [WIDTH-1:0] d,
    input  logic [AW-1:0]    amt,
    input  logic             left,
    input  logic             arith,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sra;

    // Kept in its own assignment so the signed operand stays signed and the shift stays arithmetic.
    assign sra = $signed(d) >>> amt;
    assign q   = left ? d << amt : arith ? sra : d >> amt;

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execute-stage ALU with iterative shifts and valid/ready handshakes.
module alu_mc
    import my_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  alu_op_e          ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             BIT_Branch,
    output logic             busy
);

    localparam int SW = $clog2(WIDTH);
    localparam int AW = $clog2(SHIFT_STEP + 1);
    localparam logic [SW:0]   STEP_X = (SW + 1)'(SHIFT_STEP);
    localparam logic [AW-1:0] STEP_A = AW'(SHIFT_STEP);

    alu_state_e       state;
    alu_op_e          sop;
    logic [WIDTH-1:0] acc, res, diff, step_q;
    logic [SW-1:0]    rem, rem_nx, amt;
    logic [SW:0]      rem_x;
    logic [AW-1:0]    k;
    logic             accept, start_shift, br, eq, lt, ltu;

    assign in_ready    = RST_n && (state == IDLE || (state == DONE && out_ready));
    assign accept      = in_valid && in_ready;
    assign amt         = op2[SW-1:0];
    assign start_shift = is_shift(ALUControl) && amt != '0;
    assign diff        = op1 - op2;
    assign eq          = op1 == op2;
    assign lt          = $signed(op1) < $signed(op2);
    assign ltu         = op1 < op2;

    always_comb begin
        res = diff;
        br  = 1'b0;
        case (ALUControl)
            ADD:           res = op1 + op2;
            XOR:           res = op1 ^ op2;
            OR:            res = op1 | op2;
            AND:           res = op1 & op2;
            SLL, SRL, SRA: res = op1;
            SLT:           res = {{(WIDTH-1){1'b0}}, lt};
            SLTU:          res = {{(WIDTH-1){1'b0}}, ltu};
            BEQ:           br = eq;
            BNE:           br = !eq;
            BLT:           br = lt;
            BGE:           br = !lt;
            BLTU:          br = ltu;
            BGEU:          br = !ltu;
            default:       ;
        endcase
    end

    // Last iteration may need fewer than SHIFT_STEP positions.
    assign rem_x  = {1'b0, rem};
    assign k      = rem_x < STEP_X ? rem_x[AW-1:0] : STEP_A;
    assign rem_nx = SW'(rem_x - (SW + 1)'(k));

    alu_shift_step #(.WIDTH(WIDTH), .SHIFT_STEP(SHIFT_STEP)) u_step (
        .d    (acc),
        .amt  (k),
        .left (sop == SLL),
        .arith(sop == SRA),
        .q    (step_q)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state      <= IDLE;
            sop        <= ADD;
            acc        <= '0;
            rem        <= '0;
            ALUResult  <= '0;
            BIT_Branch <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else if (accept && start_shift) begin
            state     <= SHIFT;
            busy      <= 1'b1;
            out_valid <= 1'b0;
            acc       <= op1;
            rem       <= amt;
            sop       <= ALUControl;
        end else if (accept) begin
            state      <= DONE;
            out_valid  <= 1'b1;
            ALUResult  <= res;
            BIT_Branch <= br;
        end else if (state == SHIFT) begin
            acc <= step_q;
            rem <= rem_nx;
            if (rem_nx == '0) begin
                state      <= DONE;
                busy       <= 1'b0;
                out_valid  <= 1'b1;
                ALUResult  <= step_q;
                BIT_Branch <= 1'b0;
            end
        end else if (state == DONE && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed vectors for alu_mc at SHIFT_STEP 1 and 4.
module tb_alu_mc;
    import my_pkg::*;

    logic        CLK = 1'b0, RST_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [31:0] op1 = '0, op2 = '0;
    alu_op_e     ctl = ADD;
    logic        in_ready, out_valid, BIT_Branch, busy;
    logic [31:0] ALUResult;
    logic        in_ready4, out_valid4, br4, busy4;
    logic [31:0] res4;
    int          vecs = 0, errs = 0;

    always #5 CLK = ~CLK;

    alu_mc dut (
        .CLK(CLK), .RST_n(RST_n), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .ALUControl(ctl), .out_valid(out_valid),
        .out_ready(out_ready), .ALUResult(ALUResult), .BIT_Branch(BIT_Branch), .busy(busy)
    );

    alu_mc #(.WIDTH(32), .SHIFT_STEP(4)) dut4 (
        .CLK(CLK), .RST_n(RST_n), .in_valid(in_valid), .in_ready(in_ready4),
        .op1(op1), .op2(op2), .ALUControl(ctl), .out_valid(out_valid4),
        .out_ready(out_ready), .ALUResult(res4), .BIT_Branch(br4), .busy(busy4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic br, input int lat);
        int c;
        ctl = op; op1 = a; op2 = b; in_valid = 1'b1;
        c = 0;
        do begin
            @(negedge CLK);
            in_valid = 1'b0;
            c++;
        end while (!out_valid && c < 40);
        chk({tag, ".lat"}, c, lat);
        chk({tag, ".res"}, ALUResult, res);
        chk({tag, ".br"}, BIT_Branch, br);
        @(negedge CLK);
    endtask

    initial begin
        int c1, c4, nb;
        repeat (2) @(negedge CLK);
        chk("rst.res", ALUResult, 0);
        chk("rst.ov", out_valid, 0);
        chk("rst.ir", in_ready, 0);
        chk("rst.busy", busy, 0);
        RST_n = 1'b1;
        #1 chk("rst.rel_ir", in_ready, 1);
        @(negedge CLK);
        // back-to-back single-cycle ops
        ctl = ADD; op1 = 32'hFFFF_FFFF; op2 = 32'h1; in_valid = 1'b1;
        @(negedge CLK);
        chk("add.ov", out_valid, 1);
        chk("add.res", ALUResult, 32'h0);
        chk("add.br", BIT_Branch, 0);
        chk("add.ir", in_ready, 1);
        ctl = XOR; op1 = 32'hF0F0_F0F0; op2 = 32'hFFFF_0000;
        @(negedge CLK);
        in_valid = 1'b0;
        chk("xor.ov", out_valid, 1);
        chk("xor.res", ALUResult, 32'h0F0F_F0F0);
        @(negedge CLK);
        chk("idle.ov", out_valid, 0);
        // reset in the middle of a shift
        ctl = SLL; op1 = 32'h1; op2 = 32'd31; in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        repeat (3) @(negedge CLK);
        chk("sll.busy", busy, 1);
        chk("sll.ir", in_ready, 0);
        RST_n = 1'b0;
        #1;
        chk("arst.res", ALUResult, 0);
        chk("arst.busy", busy, 0);
        chk("arst.ov", out_valid, 0);
        chk("arst.ir", in_ready, 0);
        @(negedge CLK);
        RST_n = 1'b1;
        #1 chk("arst.rel_ir", in_ready, 1);
        @(negedge CLK);
        chk("arst.ov2", out_valid, 0);
        // SRA by 31 at both step sizes, results held under backpressure
        out_ready = 1'b0;
        ctl = SRA; op1 = 32'h8000_0000; op2 = 32'd31; in_valid = 1'b1;
        c1 = 0; c4 = 0; nb = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            in_valid = 1'b0;
            if (busy) nb++;
            if (out_valid && c1 == 0) c1 = i;
            if (out_valid4 && c4 == 0) c4 = i;
        end
        chk("sra1.lat", c1, 32);
        chk("sra1.busy", nb, 31);
        chk("sra1.res", ALUResult, 32'hFFFF_FFFF);
        chk("sra4.lat", c4, 9);
        chk("sra4.res", res4, 32'hFFFF_FFFF);
        out_ready = 1'b1;
        @(negedge CLK);
        run("sra0", SRA, 32'h1234_5678, 32'h20, 32'h1234_5678, 1'b0, 1);
        run("sll4", SLL, 32'h1, 32'h4, 32'h10, 1'b0, 5);
        run("srl4", SRL, 32'h8000_0000, 32'hFFFF_FFE4, 32'h0800_0000, 1'b0, 5);
        run("sra8", SRA, 32'hF000_0000, 32'h8, 32'hFFF0_0000, 1'b0, 9);
        run("sub", SUB, 32'h5, 32'h7, 32'hFFFF_FFFE, 1'b0, 1);
        run("or", OR, 32'hF000_000F, 32'h0FF0_0000, 32'hFFF0_000F, 1'b0, 1);
        run("and", AND, 32'hF0F0_FFFF, 32'h0FF0_1234, 32'h00F0_1234, 1'b0, 1);
        run("blt", BLT, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE, 1'b1, 1);
        run("bltu", BLTU, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE, 1'b0, 1);
        run("bgeu", BGEU, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE, 1'b1, 1);
        run("unk", alu_op_e'(5'd20), 32'h7, 32'h2, 32'h5, 1'b0, 1);
        run("bge", BGE, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE, 1'b0, 1);
        run("beq", BEQ, 32'h5, 32'h5, 32'h0, 1'b1, 1);
        run("bne", BNE, 32'h5, 32'h5, 32'h0, 1'b0, 1);
        run("slt", SLT, 32'hFFFF_FFFB, 32'h3, 32'h1, 1'b0, 1);
        run("sltu", SLTU, 32'hFFFF_FFFB, 32'h3, 32'h0, 1'b0, 1);
        // backpressure with a pending request and toggling operands
        out_ready = 1'b0;
        ctl = ADD; op1 = 32'h1; op2 = 32'h2; in_valid = 1'b1;
        @(negedge CLK);
        chk("bp.ov", out_valid, 1);
        chk("bp.res", ALUResult, 32'h3);
        ctl = SUB;
        for (int i = 0; i < 5; i++) begin
            op1 = i[0] ? 32'hAAAA_5555 : 32'h5555_AAAA;
            op2 = ~op1;
            @(negedge CLK);
            chk($sformatf("bp.hold%0d", i), ALUResult, 32'h3);
            chk($sformatf("bp.ir%0d", i), in_ready, 0);
        end
        op1 = 32'd10; op2 = 32'd4; out_ready = 1'b1;
        #1 chk("bp.ir_open", in_ready, 1);
        @(negedge CLK);
        in_valid = 1'b0;
        chk("bp.next_ov", out_valid, 1);
        chk("bp.next_res", ALUResult, 32'h6);
        @(negedge CLK);
        chk("bp.idle", out_valid, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
